// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: digit count, blank
// pattern, segment bit positions and the active-low hex glyph table.
package seg_pkg;

  localparam int NDIG = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-low glyphs, bit7 (dp) held off.
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg_scan_driver_hex7seg.sv
// Combinational nibble to active-low a..g pattern decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  logic [7:0] code;

  always_comb begin
    code    = HEX_SEG[nibble];
    pattern = code[SEG_G:SEG_A];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment driver. The displayed word is
// latched once per frame so a frame never mixes nibbles from two words.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter logic [15:0] PRESCALE = 16'd50000,
  parameter logic [15:0] GAP      = 16'd500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic [7:0]  dp,
  input  logic        blank_en,
  output logic [7:0]  anode,
  output logic [7:0]  segment,
  output logic        frame_done
);

  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [31:0] value_s;
  logic [7:0]  dp_s;
  logic        blank_en_s;
  logic        slot_end;
  logic        frame_end;
  logic [7:0]  blank_mask;
  logic        nz_above;
  logic [3:0]  nibble;
  logic [6:0]  pattern;
  logic [7:0]  anode_on;

  assign slot_end  = (cnt == PRESCALE - 16'd1);
  assign frame_end = slot_end && (idx == 3'(NDIG - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Shadow registers only load at the very last cycle of digit 7.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_s    <= '0;
      dp_s       <= '0;
      blank_en_s <= 1'b0;
    end else if (frame_end) begin
      value_s    <= value;
      dp_s       <= dp;
      blank_en_s <= blank_en;
    end
  end

  // Walk from the top digit down; a digit is blanked while everything at
  // and above it is still zero. Digit 0 always shows.
  always_comb begin
    nz_above   = 1'b0;
    blank_mask = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      nz_above      = nz_above | (|value_s[4*i +: 4]);
      blank_mask[i] = blank_en_s & ~nz_above & (i != 0);
    end
  end

  assign nibble   = value_s[{idx, 2'b00} +: 4];
  assign anode_on = ~(8'h01 << idx);

  hex7seg u_hex7seg (
    .nibble  (nibble),
    .pattern (pattern)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode      <= 8'hFF;
      segment    <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      anode      <= (cnt >= GAP) ? anode_on : 8'hFF;
      segment    <= blank_mask[idx] ? SEG_BLANK : {~dp_s[idx], pattern};
    end
  end

endmodule
